fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, byte-addressed instruction memory, decode of
// instruction fields, predicted-PC register and the pipeline register into decode.
module fetch_stage #(
   parameter int IMEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_we,
   input  logic [63:0] imem_waddr,
   input  logic [7:0]  imem_wdata,
   input  logic [3:0]  M_icode,
   input  logic        M_Cnd,
   input  logic [63:0] M_valA,
   input  logic [3:0]  W_icode,
   input  logic [63:0] W_valM,
   input  logic        F_stall,
   input  logic        D_stall,
   input  logic        D_bubble,
   output logic [63:0] f_pc,
   output logic [63:0] F_predPC,
   output logic [3:0]  D_stat,
   output logic [3:0]  D_icode,
   output logic [3:0]  D_ifun,
   output logic [3:0]  D_rA,
   output logic [3:0]  D_rB,
   output logic [63:0] D_valC,
   output logic [63:0] D_valP
);

   localparam int          AW      = $clog2(IMEM_BYTES);
   localparam logic [63:0] LAST_OK = 64'(IMEM_BYTES - 10);
   localparam logic [63:0] MEM_LIM = 64'(IMEM_BYTES);

   logic [7:0]  imem [IMEM_BYTES];
   logic [7:0]  fb [10];
   logic        imem_error;
   logic        instr_valid;
   logic        need_regids;
   logic        need_valc;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic [3:0]  ra;
   logic [3:0]  rb;
   logic [63:0] valc;
   logic [63:0] valp;
   logic [63:0] pred_pc;
   logic [2:0]  stat;

   // A mispredicted branch outranks a returning ret.
   always_comb begin
      if (M_icode == 4'h7 && !M_Cnd)
         f_pc = M_valA;
      else if (W_icode == 4'h9)
         f_pc = W_valM;
      else
         f_pc = F_predPC;
   end

   always_ff @(posedge clk) begin
      if (imem_we && imem_waddr < MEM_LIM)
         imem[imem_waddr[AW-1:0]] <= imem_wdata;
   end

   // Out-of-range fetches read as nop so the rest of decode stays benign.
   always_comb begin
      imem_error = f_pc > LAST_OK;
      for (int i = 0; i < 10; i++)
         fb[i] = imem_error ? 8'h10 : imem[f_pc[AW-1:0] + AW'(i)];
   end

   always_comb begin
      instr_valid = fb[0][7:4] <= 4'hB;
      icode       = instr_valid ? fb[0][7:4] : 4'h1;
      ifun        = instr_valid ? fb[0][3:0] : 4'h0;
      need_regids = 1'b0;
      need_valc   = 1'b0;
      case (icode)
         4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
         4'h3, 4'h4, 4'h5: begin
            need_regids = 1'b1;
            need_valc   = 1'b1;
         end
         4'h7, 4'h8: need_valc = 1'b1;
         default: ;
      endcase
      ra   = need_regids ? fb[1][7:4] : 4'hF;
      rb   = need_regids ? fb[1][3:0] : 4'hF;
      valc = '0;
      if (need_valc) begin
         for (int k = 0; k < 8; k++)
            valc[8*k +: 8] = need_regids ? fb[k+2] : fb[k+1];
      end
      valp    = f_pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
      pred_pc = (icode == 4'h7 || icode == 4'h8) ? valc : valp;
      if (imem_error)
         stat = 3'd3;
      else if (!instr_valid)
         stat = 3'd4;
      else if (icode == 4'h0)
         stat = 3'd2;
      else
         stat = 3'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         F_predPC <= '0;
      else if (!F_stall)
         F_predPC <= pred_pc;
   end

   // Stall wins over bubble when both are requested.
   always_ff @(posedge clk) begin
      if (rst || (!D_stall && D_bubble)) begin
         D_stat  <= 4'd1;
         D_icode <= 4'h1;
         D_ifun  <= 4'h0;
         D_rA    <= 4'hF;
         D_rB    <= 4'hF;
         D_valC  <= '0;
         D_valP  <= '0;
      end else if (!D_stall) begin
         D_stat  <= {1'b0, stat};
         D_icode <= icode;
         D_ifun  <= ifun;
         D_rA    <= ra;
         D_rB    <= rb;
         D_valC  <= valc;
         D_valP  <= valp;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed expectations checked with
// immediate assertions after each step.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_we;
   logic [63:0] imem_waddr;
   logic [7:0]  imem_wdata;
   logic [3:0]  M_icode;
   logic        M_Cnd;
   logic [63:0] M_valA;
   logic [3:0]  W_icode;
   logic [63:0] W_valM;
   logic        F_stall;
   logic        D_stall;
   logic        D_bubble;
   logic [63:0] f_pc;
   logic [63:0] F_predPC;
   logic [3:0]  D_stat;
   logic [3:0]  D_icode;
   logic [3:0]  D_ifun;
   logic [3:0]  D_rA;
   logic [3:0]  D_rB;
   logic [63:0] D_valC;
   logic [63:0] D_valP;

   int errors = 0;
   int checks = 0;

   fetch_stage #(.IMEM_BYTES(1024)) dut (
      .clk(clk), .rst(rst),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
      .W_icode(W_icode), .W_valM(W_valM),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
      .f_pc(f_pc), .F_predPC(F_predPC),
      .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
      .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [63:0] a, input logic [7:0] d);
      imem_we    = 1'b1;
      imem_waddr = a;
      imem_wdata = d;
      tick();
      imem_we = 1'b0;
   endtask

   task automatic redirect(input logic [63:0] a);
      M_icode = 4'h7;
      M_Cnd   = 1'b0;
      M_valA  = a;
      #1;
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, "_stat"}, D_stat, 64'd1);
      chk({tag, "_icode"}, D_icode, 64'h1);
      chk({tag, "_ifun"}, D_ifun, 64'h0);
      chk({tag, "_rA"}, D_rA, 64'hF);
      chk({tag, "_rB"}, D_rB, 64'hF);
      chk({tag, "_valC"}, D_valC, 64'h0);
      chk({tag, "_valP"}, D_valP, 64'h0);
   endtask

   logic [7:0] irmov [10] = '{8'h30, 8'hF3, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] jxx   [9]  = '{8'h70, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] mrmov [10] = '{8'h50, 8'h12, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

   initial begin
      rst = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
      M_icode = 4'h0; M_Cnd = 1'b0; M_valA = '0; W_icode = 4'h0; W_valM = '0;
      F_stall = 1'b1; D_stall = 1'b1; D_bubble = 1'b1;

      // Program load happens under reset; stall/bubble must not matter.
      for (int a = 0; a < 1024; a++) wr(64'(a), 8'h00);
      for (int i = 0; i < 10; i++) wr(64'(i), irmov[i]);
      for (int i = 0; i < 9; i++) wr(64'h20 + 64'(i), jxx[i]);
      for (int i = 0; i < 10; i++) wr(64'h30 + 64'(i), mrmov[i]);
      wr(64'h10, 8'hC0);
      wr(64'd1024, 8'hFF);
      wr(64'h1_0000_0000, 8'hEE);
      chk("rst_predpc", F_predPC, 64'h0);
      chk_bubble("rst");

      rst = 1'b0; F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
      #1;
      chk("start_fpc", f_pc, 64'h0);
      tick();
      chk("irmov_icode", D_icode, 64'h3);
      chk("irmov_rA", D_rA, 64'hF);
      chk("irmov_rB", D_rB, 64'h3);
      chk("irmov_valC", D_valC, 64'h8);
      chk("irmov_valP", D_valP, 64'd10);
      chk("irmov_stat", D_stat, 64'd1);
      chk("irmov_predpc", F_predPC, 64'd10);

      redirect(64'h20);
      chk("jxx_fpc", f_pc, 64'h20);
      tick();
      chk("jxx_predpc", F_predPC, 64'h100);
      chk("jxx_icode", D_icode, 64'h7);
      chk("jxx_valC", D_valC, 64'h100);
      chk("jxx_valP", D_valP, 64'h29);
      redirect(64'h29);
      chk("mispredict_fpc", f_pc, 64'h29);
      M_Cnd = 1'b1; #1;
      chk("taken_fpc", f_pc, 64'h100);

      W_icode = 4'h9; W_valM = 64'h40;
      redirect(64'h50);
      chk("m_over_w_fpc", f_pc, 64'h50);
      M_icode = 4'h0; #1;
      chk("ret_fpc", f_pc, 64'h40);
      W_icode = 4'h0;

      redirect(64'h10);
      tick();
      chk("ins_stat", D_stat, 64'd4);
      chk("ins_icode", D_icode, 64'h1);
      chk("ins_rA", D_rA, 64'hF);
      chk("ins_valP", D_valP, 64'h11);
      redirect(64'h11);
      tick();
      chk("hlt_stat", D_stat, 64'd2);
      chk("hlt_icode", D_icode, 64'h0);
      redirect(64'd1014);
      tick();
      chk("edge_ok_stat", D_stat, 64'd2);
      chk("edge_ok_valP", D_valP, 64'd1015);
      redirect(64'd1015);
      tick();
      chk("adr_stat", D_stat, 64'd3);
      chk("adr_icode", D_icode, 64'h1);
      chk("adr_valP", D_valP, 64'd1016);

      // Write and fetch of the same byte in one cycle: old byte first.
      redirect(64'h60);
      wr(64'h60, 8'h10);
      chk("wr_old_icode", D_icode, 64'h0);
      chk("wr_old_stat", D_stat, 64'd2);
      tick();
      chk("wr_new_icode", D_icode, 64'h1);
      chk("wr_new_stat", D_stat, 64'd1);
      chk("wr_new_valP", D_valP, 64'h61);

      redirect(64'h30);
      tick();
      chk("mrmov_rA", D_rA, 64'h1);
      chk("mrmov_rB", D_rB, 64'h2);
      chk("mrmov_valC", D_valC, 64'h1122334455667788);
      chk("mrmov_valP", D_valP, 64'h3A);
      chk("mrmov_predpc", F_predPC, 64'h3A);

      M_icode = 4'h0; F_stall = 1'b1; D_stall = 1'b1;
      tick(); tick();
      chk("stall_predpc", F_predPC, 64'h3A);
      chk("stall_icode", D_icode, 64'h5);
      chk("stall_rA", D_rA, 64'h1);
      chk("stall_valC", D_valC, 64'h1122334455667788);
      chk("stall_valP", D_valP, 64'h3A);
      chk("stall_stat", D_stat, 64'd1);
      D_bubble = 1'b1;
      tick();
      chk("stall_bub_icode", D_icode, 64'h5);
      chk("stall_bub_valP", D_valP, 64'h3A);
      D_stall = 1'b0;
      tick();
      chk_bubble("bubble");
      chk("bubble_predpc", F_predPC, 64'h3A);

      F_stall = 1'b0; D_bubble = 1'b0;
      tick();
      chk("run_icode", D_icode, 64'h0);
      chk("run_predpc", F_predPC, 64'h3B);
      rst = 1'b1; D_stall = 1'b1;
      tick();
      chk("midrst_predpc", F_predPC, 64'h0);
      chk_bubble("midrst");
      rst = 1'b0; D_stall = 1'b0;
      #1;
      chk("restart_fpc", f_pc, 64'h0);
      tick();
      chk("restart_icode", D_icode, 64'h3);
      chk("restart_rB", D_rB, 64'h3);
      chk("restart_valC", D_valC, 64'h8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
